// File: rtl/systolic_fifo_ctrl_pkg.sv
// Shared types and sizing helpers for the systolic row-FIFO sequencer.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } ctrl_state_t;

    localparam int DEF_ARRAY_DIM = 4;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_TILE_W    = 8;

    // Wide enough to hold 0..dim so a count can never alias past the dimension.
    function automatic int cnt_width(input int dim);
        return (dim < 1) ? 1 : $clog2(dim + 1);
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_ARRAY_DIM);

endpackage

// File: rtl/systolic_fifo_ctrl_counter.sv
// Modulo-MAX up-counter with synchronous clear; 'last' flags the final count before wrap.
module systolic_fifo_ctrl_counter
    import systolic_pkg::*;
#(
    parameter int MAX = DEF_ARRAY_DIM,
    parameter int W   = cnt_width(MAX)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic last
);

    localparam logic [W-1:0] LAST_VAL = W'(MAX - 1);

    logic [W-1:0] count;

    // 'last' is independent of 'en' so the caller can gate it without a combinational loop.
    assign last = (count == LAST_VAL);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (en) begin
            count <= last ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/systolic_fifo_ctrl.sv
// Sequencer for one systolic row-FIFO: loads ARRAY_DIM rows, shifts ARRAY_DIM times, per tile.
//
// state | meaning
// IDLE  | waiting for start; counters held clear
// FILL  | accepting upstream rows into the FIFO
// DRAIN | shifting FIFO rows into the array while it is ready
// DONE  | one-cycle completion pulse, then back to IDLE
module systolic_fifo_ctrl
    import systolic_pkg::*;
#(
    parameter int ARRAY_DIM = DEF_ARRAY_DIM,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int TILE_W    = DEF_TILE_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          abort,
    input  logic [TILE_W-1:0]             cfg_num_tiles,
    input  logic                          row_valid,
    input  logic [DATA_W*ARRAY_DIM-1:0]   row_data,
    output logic                          row_ready,
    output logic                          fifo_load,
    output logic                          fifo_shift,
    output logic [DATA_W*ARRAY_DIM-1:0]   fifo_load_values,
    input  logic                          array_ready,
    output logic                          array_valid,
    output logic                          busy,
    output logic                          done,
    output logic [TILE_W-1:0]             tile_idx
);

    localparam int CNT_W = cnt_width(ARRAY_DIM);

    ctrl_state_t       state;
    ctrl_state_t       state_next;
    logic [TILE_W-1:0] tiles_latched;
    logic [TILE_W-1:0] tiles_next;
    logic [TILE_W-1:0] tile_idx_next;
    logic [TILE_W:0]   tile_inc;
    logic              more_tiles;
    logic              cnt_clear;
    logic              row_last;
    logic              shift_last;

    // One extra bit so tile_idx+1 cannot overflow when tiles_latched is all ones.
    assign tile_inc   = {1'b0, tile_idx} + (TILE_W+1)'(1);
    assign more_tiles = (tile_inc < {1'b0, tiles_latched});
    assign busy       = (state != IDLE);

    always_comb begin
        state_next       = state;
        tiles_next       = tiles_latched;
        tile_idx_next    = tile_idx;
        cnt_clear        = 1'b0;
        row_ready        = 1'b0;
        fifo_load        = 1'b0;
        fifo_shift       = 1'b0;
        fifo_load_values = '0;
        array_valid      = 1'b0;
        done             = 1'b0;

        case (state)
            IDLE: begin
                cnt_clear = 1'b1;
                if (start && !abort) begin
                    tiles_next    = cfg_num_tiles;
                    tile_idx_next = '0;
                    state_next    = (cfg_num_tiles == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                row_ready        = 1'b1;
                fifo_load        = row_valid;
                fifo_load_values = row_data;
                if (row_valid && row_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                array_valid = 1'b1;
                fifo_shift  = array_ready;
                if (array_ready && shift_last) begin
                    if (more_tiles) begin
                        tile_idx_next = tile_inc[TILE_W-1:0];
                        state_next    = FILL;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Abort (and reset, which dominates it) silences the FIFO/array strobes in the same cycle.
        if (rst || (abort && state != IDLE)) begin
            state_next       = IDLE;
            tile_idx_next    = '0;
            cnt_clear        = 1'b1;
            row_ready        = 1'b0;
            fifo_load        = 1'b0;
            fifo_shift       = 1'b0;
            fifo_load_values = '0;
            array_valid      = 1'b0;
            done             = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            tiles_latched <= '0;
            tile_idx      <= '0;
        end else begin
            state         <= state_next;
            tiles_latched <= tiles_next;
            tile_idx      <= tile_idx_next;
        end
    end

    systolic_fifo_ctrl_counter #(
        .MAX (ARRAY_DIM),
        .W   (CNT_W)
    ) u_row_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear),
        .en    (fifo_load),
        .last  (row_last)
    );

    systolic_fifo_ctrl_counter #(
        .MAX (ARRAY_DIM),
        .W   (CNT_W)
    ) u_shift_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear),
        .en    (fifo_shift),
        .last  (shift_last)
    );

endmodule

// File: tb/tb_systolic_fifo_ctrl.sv
// Scoreboard bench: directed jobs push expected load/shift/done events; a negedge monitor pops and compares.
module tb_systolic_fifo_ctrl;

    localparam int AD = 4;
    localparam int DW = 16;
    localparam int TW = 8;

    typedef struct {
        int          cyc;
        logic [63:0] data;
        int          tile;
    } ev_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic [TW-1:0]     cfg_num_tiles;
    logic              row_valid;
    logic [DW*AD-1:0]  row_data;
    logic              row_ready;
    logic              fifo_load;
    logic              fifo_shift;
    logic [DW*AD-1:0]  fifo_load_values;
    logic              array_ready;
    logic              array_valid;
    logic              busy;
    logic              done;
    logic [TW-1:0]     tile_idx;

    int  cyc = 0;
    int  compared = 0;
    int  mismatched = 0;
    int  busy_lo = 1;
    int  busy_hi = 0;
    bit  mon_en = 1'b0;
    int  t0;
    ev_t load_q[$];
    ev_t shift_q[$];
    ev_t done_q[$];

    systolic_fifo_ctrl #(.ARRAY_DIM(AD), .DATA_W(DW), .TILE_W(TW)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .abort            (abort),
        .cfg_num_tiles    (cfg_num_tiles),
        .row_valid        (row_valid),
        .row_data         (row_data),
        .row_ready        (row_ready),
        .fifo_load        (fifo_load),
        .fifo_shift       (fifo_shift),
        .fifo_load_values (fifo_load_values),
        .array_ready      (array_ready),
        .array_valid      (array_valid),
        .busy             (busy),
        .done             (done),
        .tile_idx         (tile_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] rep(input int v);
        logic [15:0] e;
        e = 16'(v);
        return {e, e, e, e};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s @cycle %0d: got strobe, expected none", name, cyc);
    endtask

    task automatic push(input int kind, input int c, input logic [63:0] d, input int tl);
        ev_t e;
        e.cyc = c; e.data = d; e.tile = tl;
        case (kind)
            0:       load_q.push_back(e);
            1:       shift_q.push_back(e);
            default: done_q.push_back(e);
        endcase
    endtask

    // Monitor: every strobe must match the head of its expectation queue.
    always @(negedge clk) begin
        if (mon_en) begin
            ev_t e;
            chk("busy", 64'(busy), 64'((cyc >= busy_lo) && (cyc <= busy_hi)));
            chk("load_shift_excl", 64'(fifo_load & fifo_shift), 64'd0);
            if (fifo_load) begin
                if (load_q.size() == 0) unexpected("unexpected_load");
                else begin
                    e = load_q.pop_front();
                    chk("load_cycle", 64'(cyc), 64'(e.cyc));
                    chk("load_data", fifo_load_values, e.data);
                    chk("load_tile", 64'(tile_idx), 64'(e.tile));
                end
            end
            if (fifo_shift) begin
                if (shift_q.size() == 0) unexpected("unexpected_shift");
                else begin
                    e = shift_q.pop_front();
                    chk("shift_cycle", 64'(cyc), 64'(e.cyc));
                    chk("shift_array_valid", 64'(array_valid), 64'd1);
                end
            end
            if (done) begin
                if (done_q.size() == 0) unexpected("unexpected_done");
                else begin
                    e = done_q.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(e.cyc));
                    chk("done_tile", 64'(tile_idx), 64'(e.tile));
                end
            end
        end
    end

    task automatic sync();
        @(posedge clk); #1;
        t0 = cyc;
    endtask

    // Drives one job of fixed length starting in the current cycle (rel 0 = start cycle).
    task automatic run_job(input int ntiles, input int len, input logic [63:0] rv_stall,
                           input logic [63:0] ar_stall, input int abort_rel, input int rst_rel,
                           input int xstart_rel, input int xcfg);
        for (int rel = 0; rel < len; rel++) begin
            if (rel > 0) begin @(posedge clk); #1; end
            start         = (rel == 0) || (rel == xstart_rel);
            cfg_num_tiles = (rel == 0) ? TW'(ntiles) : ((rel == xstart_rel) ? TW'(xcfg) : 8'd7);
            row_valid     = ~rv_stall[rel];
            array_ready   = ~ar_stall[rel];
            row_data      = rep(rel);
            abort         = (rel == abort_rel);
            rst           = (rel == rst_rel);
            if (rel == abort_rel) begin
                @(negedge clk);
                chk("abort_row_ready", 64'(row_ready), 64'd0);
                chk("abort_array_valid", 64'(array_valid), 64'd0);
            end
            if (abort_rel >= 0 && rel == abort_rel + 1) begin
                @(negedge clk);
                chk("abort_tile_idx_clr", 64'(tile_idx), 64'd0);
            end
            if (rst_rel >= 0 && rel == rst_rel + 1) begin
                @(negedge clk);
                chk("rst_row_ready", 64'(row_ready), 64'd0);
                chk("rst_array_valid", 64'(array_valid), 64'd0);
                chk("rst_load", 64'(fifo_load), 64'd0);
            end
        end
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0; rst = 1'b0; row_valid = 1'b0; array_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("leftover_loads", 64'(load_q.size()), 64'd0);
        chk("leftover_shifts", 64'(shift_q.size()), 64'd0);
        chk("leftover_dones", 64'(done_q.size()), 64'd0);
    endtask

    task automatic expect_clean_tile(input int base, input int tile);
        for (int k = 1; k <= AD; k++) push(0, t0 + base + k, rep(base + k), tile);
        for (int k = 1; k <= AD; k++) push(1, t0 + base + AD + k, '0, tile);
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; abort = 1'b0; cfg_num_tiles = 8'd1;
        row_valid = 1'b1; array_ready = 1'b1; row_data = rep(9);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_fifo_load", 64'(fifo_load), 64'd0);
        chk("rst_row_ready", 64'(row_ready), 64'd0);
        chk("rst_load_values", fifo_load_values, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; row_valid = 1'b0; array_ready = 1'b0;
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_done", 64'(done), 64'd0);
        chk("idle_tile_idx", 64'(tile_idx), 64'd0);
        chk("idle_shift", 64'(fifo_shift), 64'd0);
        mon_en = 1'b1;

        // 1: single tile, no stalls
        sync(); busy_lo = t0 + 1; busy_hi = t0 + 9;
        expect_clean_tile(0, 0);
        push(2, t0 + 9, '0, 0);
        run_job(1, 11, 64'd0, 64'd0, -1, -1, -1, 0);

        // 2: three tiles, tile_idx steps at cycles 9 and 17, done at 25
        sync(); busy_lo = t0 + 1; busy_hi = t0 + 25;
        for (int t = 0; t < 3; t++) expect_clean_tile(8 * t, t);
        push(2, t0 + 25, '0, 2);
        run_job(3, 27, 64'd0, 64'd0, -1, -1, -1, 0);

        // 3: row_valid low in 2-3, array_ready low in 7
        sync(); busy_lo = t0 + 1; busy_hi = t0 + 12;
        push(0, t0 + 1, rep(1), 0);
        push(0, t0 + 4, rep(4), 0);
        push(0, t0 + 5, rep(5), 0);
        push(0, t0 + 6, rep(6), 0);
        for (int k = 8; k <= 11; k++) push(1, t0 + k, '0, 0);
        push(2, t0 + 12, '0, 0);
        run_job(1, 14, 64'h0C, 64'h80, -1, -1, -1, 0);

        // 4: zero tiles goes straight to DONE
        sync(); busy_lo = t0 + 1; busy_hi = t0 + 1;
        push(2, t0 + 1, '0, 0);
        run_job(0, 4, 64'd0, 64'd0, -1, -1, -1, 0);

        // 5: abort in tile 1 DRAIN after two shifts, then a clean restart
        sync(); busy_lo = t0 + 1; busy_hi = t0 + 15;
        expect_clean_tile(0, 0);
        for (int k = 9; k <= 12; k++) push(0, t0 + k, rep(k), 1);
        push(1, t0 + 13, '0, 1);
        push(1, t0 + 14, '0, 1);
        run_job(2, 17, 64'd0, 64'd0, 15, -1, -1, 0);
        sync(); busy_lo = t0 + 1; busy_hi = t0 + 9;
        expect_clean_tile(0, 0);
        push(2, t0 + 9, '0, 0);
        run_job(1, 11, 64'd0, 64'd0, -1, -1, -1, 0);

        // 6a: reset with start in mid-FILL
        sync(); busy_lo = t0 + 1; busy_hi = t0 + 2;
        push(0, t0 + 1, rep(1), 0);
        run_job(1, 6, 64'd0, 64'd0, -1, 2, 2, 1);

        // 6b: start while busy with a different count is ignored
        sync(); busy_lo = t0 + 1; busy_hi = t0 + 9;
        expect_clean_tile(0, 0);
        push(2, t0 + 9, '0, 0);
        run_job(1, 14, 64'd0, 64'd0, -1, -1, 2, 3);

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/systolic_fifo_ctrl.md
Name: systolic_fifo_ctrl

Overview:
Sequencer for one systolic_array_fifo_if row-FIFO instance feeding the systolic array.
- Accepts matrix rows from upstream over a valid/ready handshake.
- Drives FIFO load for ARRAY_DIM rows, then drives shift for ARRAY_DIM cycles while the array is ready.
- Repeats for a configured number of tiles and reports busy/done to the top-level tensor-core controller.

Parameters:
ARRAY_DIM, 4, systolic array dimension (rows per tile, shifts per tile).
DATA_W, 16, element width (FP16).
TILE_W, 8, width of tile count configuration.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  reset, synchronous, active-high.
start  in  1  begin job; sampled only in IDLE.
abort  in  1  synchronous cancel; return to IDLE without done.
cfg_num_tiles  in  TILE_W  tiles in job; latched on accepted start.
row_valid  in  1  upstream row available.
row_data  in  DATA_W*ARRAY_DIM  upstream row, element 0 in LSBs.
row_ready  out  1  controller accepts row this cycle.
fifo_load  out  1  to FIFO load.
fifo_shift  out  1  to FIFO shift.
fifo_load_values  out  DATA_W*ARRAY_DIM  to FIFO load_values.
array_ready  in  1  array can consume a FIFO output this cycle.
array_valid  out  1  FIFO out presents a valid tile row this cycle.
busy  out  1  state != IDLE.
done  out  1  one-cycle pulse at job completion.
tile_idx  out  TILE_W  index of current tile, 0-based.

Behaviour:
- Reset: state=IDLE; row_cnt, shift_cnt, tile_idx, tiles_latched = 0; all outputs 0.
- Reset wins over abort, abort wins over start.
- States: IDLE, FILL, DRAIN, DONE.
- IDLE:
  - start=1 latches cfg_num_tiles and clears tile_idx.
  - If cfg_num_tiles=0, go to DONE; otherwise go to FILL.
  - start while busy is ignored.
- FILL:
  - row_ready=1.
  - fifo_load = row_valid & row_ready (combinational); fifo_load_values = row_data (combinational passthrough; 0 when not FILL).
  - Each accepted row increments row_cnt.
  - On the ARRAY_DIM-th accepted row: go to DRAIN, row_cnt=0.
- DRAIN:
  - array_valid=1; fifo_shift = array_ready; row_ready=0.
  - Each shift increments shift_cnt.
  - On the ARRAY_DIM-th shift: shift_cnt=0.
    - If tile_idx+1 < tiles_latched, increment tile_idx and go to FILL.
    - Otherwise go to DONE.
  - array_ready=0 stalls: counter holds, no shift.
- DONE: done=1 for exactly one cycle, then IDLE. busy=1 in DONE.
- Invariant: fifo_load and fifo_shift are never high in the same cycle.
- Latency with no stalls, start accepted at cycle 0 and D=ARRAY_DIM:
  - row_ready first high in cycle 1.
  - First shift in cycle D+1.
  - done in cycle 2*D*N+1 for N tiles.
  - Each stalled cycle (row_valid=0 in FILL, array_ready=0 in DRAIN) adds one cycle.
- abort (any non-IDLE state):
  - Next state is IDLE; counters and tile_idx cleared; no done pulse.
  - Outputs row_ready, fifo_load, fifo_shift and array_valid are forced 0 in the abort cycle.
- Counters are clog2(ARRAY_DIM+1) bits wide and never wrap past ARRAY_DIM. tile_idx wraps only by restart.

Decomposition:
- Package systolic_pkg:
  - ctrl_state_t enum {IDLE, FILL, DRAIN, DONE}.
  - Localparams for counter width (clog2) and the default ARRAY_DIM/DATA_W.
- No sub-module required. Row and shift counters are inline.
- Optionally share a generic mod_counter (enable, clear, terminal-count flag) for row_cnt and shift_cnt.

Test Plan:
1. D=4, N=1, row_valid and array_ready held high, start at cycle 0: fifo_load in cycles 1-4 with rows 0x0001..0x0004 (per element), fifo_shift in cycles 5-8, done=1 only at cycle 9, busy 1..9.
2. N=3, no stalls: tile_idx steps 0→1→2 at cycles 9 and 17; done at cycle 25; load/shift never simultaneous.
3. Backpressure: row_valid low in cycles 2-3 and array_ready low in cycle 7 → exactly 4 loads and 4 shifts, done delayed by 3 cycles to cycle 12; no shift while array_ready=0.
4. cfg_num_tiles=0 with start → DONE at cycle 1, done pulse, no load/shift ever asserted.
5. abort asserted during DRAIN after 2 shifts → IDLE next cycle, no done, counters 0. A following start runs a full clean tile (4 loads, 4 shifts).
6. rst asserted mid-FILL together with start → all outputs 0 next cycle, state IDLE. start while busy is ignored (tiles_latched unchanged).
